// File: rtl/fifo_rr_drain.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rr_drain
//  Description : Round-robin drain of N showahead FIFOs onto one registered
//                valid/ready output stream. A granted source keeps the grant
//                for at most BURST_LEN words, then the grant rotates.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rr_drain #(
    parameter int N         = 4,
    parameter int DWIDTH    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic                    clk_i,
    input  logic                    srst_i,
    input  logic [N-1:0]            src_en_i,
    input  logic [N-1:0]            fifo_empty_i,
    input  logic [N*DWIDTH-1:0]     fifo_q_i,
    output logic [N-1:0]            fifo_rdreq_o,
    output logic [DWIDTH-1:0]       data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [$clog2(N)-1:0]    src_o,
    output logic                    busy_o
);

    localparam int SRC_W = $clog2(N);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [SRC_W:0]   C_N_EXT     = (SRC_W+1)'(N);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SRC_W-1:0]       gnt_q, gnt_d;
    logic [SRC_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       burst_cnt_q, burst_cnt_d;
    logic [DWIDTH-1:0]      data_q, data_d;
    logic [SRC_W-1:0]       src_q, src_d;
    logic                   valid_q, valid_d;

    logic [N-1:0]           w_cand;
    logic                   w_pick_vld;
    logic [SRC_W-1:0]       w_pick;
    logic [SRC_W:0]         w_sum;
    logic [SRC_W-1:0]       w_idx;
    logic                   w_load;
    logic                   w_pop;
    logic [DWIDTH-1:0]      w_q_arr [N];

    // Split the flat FIFO data bus into one word per source
    generate
        for (genvar k = 0; k < N; k++) begin : g_unpack
            assign w_q_arr[k] = fifo_q_i[k*DWIDTH +: DWIDTH];
        end
    endgenerate

    assign w_cand = src_en_i & ~fifo_empty_i;
    assign w_load = !valid_q || ready_i;

    // Round-robin search: first candidate after rr_ptr, wrapping modulo N
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick     = '0;
        w_sum      = '0;
        w_idx      = '0;
        for (int i = 1; i <= N; i++) begin
            w_sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(i);
            if (w_sum >= C_N_EXT) begin
                w_sum = w_sum - C_N_EXT;
            end
            w_idx = w_sum[SRC_W-1:0];
            if (!w_pick_vld && w_cand[w_idx]) begin
                w_pick_vld = 1'b1;
                w_pick     = w_idx;
            end
        end
    end

    // Next-state, burst counting and output-register loading
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        data_d      = data_q;
        src_d       = src_q;
        valid_d     = valid_q;
        w_pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Arbitration cycle: nothing is popped here
                if (w_pick_vld) begin
                    state_d     = ST_BURST;
                    gnt_d       = w_pick;
                    rr_ptr_d    = w_pick;
                    burst_cnt_d = '0;
                end
            end
            ST_BURST: begin
                w_pop = w_load && !fifo_empty_i[gnt_q];
                if (w_pop) begin
                    data_d      = w_q_arr[gnt_q];
                    src_d       = gnt_q;
                    valid_d     = 1'b1;
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    if (burst_cnt_q == C_LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end
                end else if (w_load) begin
                    // Granted source ran dry; stalls (load=0) never end a burst
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Output register free but no new word: the slot empties
        if (w_load && !w_pop) begin
            valid_d = 1'b0;
        end
    end

    // Read strobe to the granted FIFO, suppressed during reset
    always_comb begin
        fifo_rdreq_o = '0;
        if (w_pop && !srst_i) begin
            fifo_rdreq_o[gnt_q] = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            rr_ptr_q    <= SRC_W'(N - 1);
            burst_cnt_q <= '0;
            data_q      <= '0;
            src_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            data_q      <= data_d;
            src_q       <= src_d;
            valid_q     <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign src_o   = src_q;
    assign busy_o  = (state_q == ST_BURST);

endmodule
`default_nettype wire

// File: doc/fifo_rr_drain.md
Name: fifo_rr_drain

Overview:
- Drains N showahead FIFOs onto a single registered output stream with valid/ready handshake.
- Round-robin scheduling: a source holds the grant for at most BURST_LEN words, then the grant rotates.
- Sits between the per-channel fifo instances (SHOWAHEAD=1) and a shared downstream consumer.
- Drives each FIFO's rdreq_i; consumes each FIFO's q_o and empty_o.

Parameters:
- N, 4: number of source FIFOs, 2..16.
- DWIDTH, 32: word width. Must match the FIFO DWIDTH.
- BURST_LEN, 4: maximum words popped per grant, 1..255.
- SRC_W, $clog2(N): width of the source index (localparam).

Ports:
- clk_i  in  1  clock.
- srst_i  in  1  synchronous reset, active-high.
- src_en_i  in  N  per-source enable. A disabled source is never newly granted.
- fifo_empty_i  in  N  empty_o of each FIFO.
- fifo_q_i  in  N*DWIDTH  q_o of each FIFO; source k occupies bits [k*DWIDTH +: DWIDTH].
- fifo_rdreq_o  out  N  rdreq_i to each FIFO; combinational, at most one bit set.
- data_o  out  DWIDTH  output word, registered.
- valid_o  out  1  output word valid, registered.
- ready_i  in  1  downstream accepts data_o when valid_o && ready_i.
- src_o  out  SRC_W  source index of the word currently in data_o, registered.
- busy_o  out  1  1 while in state BURST.

Behaviour:
- Reset values: state=IDLE, rr_ptr=N-1, burst_cnt=0, valid_o=0, data_o=0, src_o=0, busy_o=0. fifo_rdreq_o=0 while srst_i=1.
- load = !valid_o || ready_i. The output register accepts a new word only when load=1.
- State IDLE:
  - cand = src_en_i & ~fifo_empty_i.
  - If cand!=0, pick the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo N.
  - Register the pick as gnt, set rr_ptr=gnt, burst_cnt=0, go to BURST.
  - No pop occurs in IDLE, so there is 1 cycle of arbitration overhead per grant.
- State BURST:
  - pop = load && !fifo_empty_i[gnt].
  - fifo_rdreq_o[gnt] = pop.
  - On pop: data_o <= fifo_q_i[gnt], src_o <= gnt, valid_o <= 1, burst_cnt++.
  - If load && !pop: valid_o <= 0.
  - If !load: data_o, src_o and valid_o hold.
- BURST exits to IDLE when either:
  - pop && burst_cnt==BURST_LEN-1 (burst complete), or
  - load && fifo_empty_i[gnt] (source drained; pop=0 that cycle).
- Backpressure never ends a burst; a stalled burst waits indefinitely.
- Deasserting src_en_i[gnt] mid-burst does not end the burst; it only blocks the next grant.
- Handshake: data_o, src_o and valid_o are stable while valid_o && !ready_i. No word is lost or duplicated.
- Latency: the first word of a grant appears on valid_o 2 cycles after cand goes nonzero with the output register free.
- Throughput: BURST_LEN words per BURST_LEN+1 cycles under continuous ready_i.
- The N=1 corner is excluded by the parameter range (N>=2).
- fifo_empty_i is trusted to update the cycle after a pop, so no word beyond the last valid one is popped.
- srst_i mid-burst: state returns to IDLE and valid_o clears next cycle. An in-flight data_o word is dropped; the FIFOs are reset by the same srst_i.
- Round-robin fairness: with all sources continuously nonempty and ready_i=1, grant order is 0,1,...,N-1,0,...

Test Plan:
- Reset, then FIFO0 holds A0..A5, others empty, ready_i=1. Expect two bursts: A0..A3 with src_o=0, one IDLE cycle (valid_o=0), then A4..A5. busy_o drops after A5.
- All 4 FIFOs hold 8 words each, ready_i=1. Expect src_o sequence 0×4,1×4,2×4,3×4,0×4,... One bubble per grant; 32 words total, none reordered within a source.
- FIFO2 holds 3 words, ready_i toggling 1,0,1,0. Expect data_o and src_o stable during each ready_i=0 cycle. fifo_rdreq_o[2] only when load=1; exactly 3 pops.
- FIFOs 1 and 3 nonempty, src_en_i=4'b0111. Expect only source 1 granted; FIFO3 is never popped and fifo_rdreq_o[3]=0 throughout.
- FIFO0 holds 1 word, BURST_LEN=4. Expect 1 pop, then exit to IDLE on empty. Write to FIFO1 the same cycle: FIFO1 is granted next, not FIFO0.
- Assert srst_i during the 2nd word of a burst with ready_i=0. Next cycle: valid_o=0, busy_o=0, fifo_rdreq_o=0. After release, arbitration restarts at source 0.
